// File: rtl/sigmoid_pkg.sv
// sigmoid_pkg: shared types and defaults for the sigmoid batch sequencer
// Contents: default data/address widths, timeout, operand type, FSM state enum.
package sigmoid_pkg;
    localparam int SIG_DW      = 32;
    localparam int SIG_AW      = 4;
    localparam int SIG_TIMEOUT = 7;
    typedef logic [SIG_DW-1:0] sig_word_t;
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, RUN, WRITE, FINISH} sig_seq_state_e;
endpackage

// File: rtl/sigmoid_seq_ctrl_if.sv
// sigmoid_seq_ctrl_if: source/destination buffer ports and sigmoid unit handshake
// master: the sequencer; slave: buffers plus sigmoid unit.
// src_rd_en/src_addr/src_rdata, dst_wr_en/dst_addr/dst_wdata,
// sig_en/sig_data_in/sig_done/sig_data_out.
interface sigmoid_seq_ctrl_if import sigmoid_pkg::*; #(
    parameter int DW = SIG_DW,
    parameter int AW = SIG_AW
);
    logic          src_rd_en;
    logic [AW-1:0] src_addr;
    logic [DW-1:0] src_rdata;
    logic          dst_wr_en;
    logic [AW-1:0] dst_addr;
    logic [DW-1:0] dst_wdata;
    logic          sig_en;
    logic [DW-1:0] sig_data_in;
    logic          sig_done;
    logic [DW-1:0] sig_data_out;
    modport master (
        output src_rd_en, src_addr, dst_wr_en, dst_addr, dst_wdata, sig_en, sig_data_in,
        input  src_rdata, sig_done, sig_data_out
    );
    modport slave (
        input  src_rd_en, src_addr, dst_wr_en, dst_addr, dst_wdata, sig_en, sig_data_in,
        output src_rdata, sig_done, sig_data_out
    );
endinterface

// File: rtl/sigmoid_seq_ctrl.sv
// sigmoid_seq_ctrl: runs one sigmoid unit over len source words into a destination buffer
// clk, rstn (async active-low); start/abort pulses, len sampled on start;
// busy level, done 1-cycle pulse at batch end, err sticky timeout flag;
// bus: buffer read/write ports and sigmoid unit handshake.
module sigmoid_seq_ctrl import sigmoid_pkg::*; #(
    parameter int DW      = SIG_DW,
    parameter int AW      = SIG_AW,
    parameter int TIMEOUT = SIG_TIMEOUT
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic [AW:0]        len,
    output logic               busy,
    output logic               done,
    output logic               err,
    sigmoid_seq_ctrl_if.master bus
);
    localparam logic [AW:0] MAX_LEN = (AW+1)'(1 << AW);
    localparam logic [AW:0] ONE     = (AW+1)'(1);
    localparam logic [2:0]  TO_LAST = 3'(TIMEOUT - 1);
    sig_seq_state_e state, nxt;
    // idx is one bit wider than the address so the last word never wraps
    logic [AW:0]   idx, len_q, idx_inc;
    logic [2:0]    tcnt;
    logic [DW-1:0] op_q, res_q;
    assign idx_inc = idx + ONE;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? ((len == '0) ? FINISH : FETCH) : IDLE;
            FETCH:   nxt = LOAD;
            LOAD:    nxt = RUN;
            RUN:     nxt = bus.sig_done ? WRITE : (tcnt == TO_LAST) ? FINISH : RUN;
            WRITE:   nxt = (idx_inc == len_q) ? FINISH : FETCH;
            default: nxt = IDLE;
        endcase
        if (abort && state != IDLE && state != FINISH)
            nxt = FINISH;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            idx   <= '0;
            len_q <= '0;
            tcnt  <= '0;
            op_q  <= '0;
            res_q <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= nxt;
            done  <= state == FINISH;
            tcnt  <= (state == RUN) ? tcnt + 3'd1 : 3'd0;
            if (state == IDLE && start) begin
                len_q <= (len > MAX_LEN) ? MAX_LEN : len;
                idx   <= '0;
                err   <= 1'b0;
            end
            if (state == LOAD)
                op_q <= bus.src_rdata;
            if (state == RUN && bus.sig_done)
                res_q <= bus.sig_data_out;
            if (state == RUN && !bus.sig_done && tcnt == TO_LAST)
                err <= 1'b1;
            if (state == WRITE && nxt == FETCH)
                idx <= idx_inc;
        end
    end
    assign busy            = state != IDLE;
    assign bus.src_rd_en   = state == FETCH;
    assign bus.src_addr    = idx[AW-1:0];
    assign bus.dst_wr_en   = state == WRITE;
    assign bus.dst_addr    = idx[AW-1:0];
    assign bus.dst_wdata   = res_q;
    assign bus.sig_en      = state == RUN;
    assign bus.sig_data_in = op_q;
endmodule

// File: tb/tb_sigmoid_seq_ctrl.sv
// tb_sigmoid_seq_ctrl: directed vector bench for the sigmoid batch sequencer
module tb_sigmoid_seq_ctrl;
    import sigmoid_pkg::*;
    localparam int AW = SIG_AW;
    typedef struct {
        logic [AW:0] len;
        int          lat;
        bit          stub;
        int          exp_wr;
        int          exp_en;
        logic        exp_err;
    } vec_t;
    logic        clk = 1'b0;
    logic        rstn;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [AW:0] len = '0;
    logic        busy, done, err;
    int          total = 0;
    int          bad = 0;
    sigmoid_seq_ctrl_if bus ();
    sigmoid_seq_ctrl dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .len(len),
        .busy(busy), .done(done), .err(err), .bus(bus)
    );
    always #5 clk = ~clk;
    sig_word_t src_mem [16];
    int        lat = 1;
    bit        stub = 1'b0;
    int        ucnt;
    function automatic sig_word_t unit_f(input sig_word_t x);
        return {x[15:0], x[31:16]} ^ 32'h5A5A_0F0F;
    endfunction
    always @(posedge clk or negedge rstn)
        if (!rstn) ucnt <= 0;
        else ucnt <= bus.sig_en ? ucnt + 1 : 0;
    assign bus.sig_done     = bus.sig_en && !stub && ucnt == lat;
    assign bus.sig_data_out = unit_f(bus.sig_data_in);
    always @(posedge clk)
        if (bus.src_rd_en) bus.src_rdata <= src_mem[bus.src_addr];
    int           nw, ndone, en_cnt, low_run, gap_bad;
    bit           seen_en;
    logic [AW-1:0] w_addr [64];
    sig_word_t     w_data [64];
    always @(negedge clk) begin
        if (bus.dst_wr_en) begin
            if (nw < 64) begin
                w_addr[nw] = bus.dst_addr;
                w_data[nw] = bus.dst_wdata;
            end
            nw++;
        end
        if (done) ndone++;
        if (bus.sig_en) begin
            if (low_run > 0 && seen_en && low_run < 3) gap_bad++;
            seen_en = 1'b1;
            low_run = 0;
            en_cnt++;
        end else begin
            low_run++;
        end
    end
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic clear();
        nw = 0; ndone = 0; en_cnt = 0; low_run = 0; gap_bad = 0; seen_en = 1'b0;
    endtask
    task automatic pulse_start(input logic [AW:0] l);
        @(posedge clk); #1;
        len = l;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) chk("done_timeout", 64'(cyc), 64'(0));
    endtask
    task automatic settle();
        repeat (2) begin @(posedge clk); #1; end
    endtask
    task automatic wait_word1();
        int k = 0;
        while (!(bus.sig_en && nw == 1) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) chk("word1_timeout", 64'(k), 64'(0));
    endtask
    task automatic check_writes(input string tag, input int n);
        for (int i = 0; i < n && i < nw && i < 64; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 64'(w_addr[i]), 64'(i));
            chk($sformatf("%s_data%0d", tag, i), 64'(w_data[i]), 64'(unit_f(src_mem[i])));
        end
    endtask
    vec_t vt [6];
    int   cyc;
    initial begin
        vt[0] = '{5'd4,  1, 1'b0, 4,  8,  1'b0};
        vt[1] = '{5'd4,  3, 1'b0, 4,  16, 1'b0};
        vt[2] = '{5'd3,  1, 1'b1, 0,  7,  1'b1};
        vt[3] = '{5'd1,  2, 1'b0, 1,  3,  1'b0};
        vt[4] = '{5'd20, 1, 1'b0, 16, 32, 1'b0};
        vt[5] = '{5'd31, 3, 1'b0, 16, 64, 1'b0};
        src_mem[0] = 32'hFFFF_0000;
        src_mem[1] = 32'hFFFF_C000;
        src_mem[2] = 32'h0000_4000;
        src_mem[3] = 32'h0001_0000;
        for (int i = 4; i < 16; i++) src_mem[i] = 32'(i) * 32'h1000_0000 + 32'h0ABC + 32'(i);
        clear();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 64'({busy, done, err, bus.sig_en, bus.src_rd_en, bus.dst_wr_en}), 64'(0));
        rstn = 1'b1;
        // reset in the middle of word 1's RUN, then a clean batch from idx 0
        clear();
        lat = 3; stub = 1'b0;
        pulse_start(5'd4);
        wait_word1();
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("midrst_outs", 64'({busy, done, err, bus.sig_en, bus.src_rd_en, bus.dst_wr_en}), 64'(0));
        chk("midrst_regs", 64'({bus.dst_addr, bus.src_addr, bus.sig_data_in}), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_nowrite", 64'(nw), 64'(1));
        rstn = 1'b1;
        clear();
        lat = 1;
        pulse_start(5'd2);
        wait_done(cyc);
        settle();
        chk("postrst_writes", 64'(nw), 64'(2));
        chk("postrst_done", 64'(ndone), 64'(1));
        check_writes("postrst", 2);
        // table-driven batches
        for (int v = 0; v < 6; v++) begin
            clear();
            lat = vt[v].lat;
            stub = vt[v].stub;
            pulse_start(vt[v].len);
            wait_done(cyc);
            settle();
            chk($sformatf("v%0d_writes", v), 64'(nw), 64'(vt[v].exp_wr));
            chk($sformatf("v%0d_en_cycles", v), 64'(en_cnt), 64'(vt[v].exp_en));
            chk($sformatf("v%0d_err", v), 64'(err), 64'(vt[v].exp_err));
            chk($sformatf("v%0d_done_pulses", v), 64'(ndone), 64'(1));
            chk($sformatf("v%0d_busy", v), 64'(busy), 64'(0));
            chk($sformatf("v%0d_gap", v), 64'(gap_bad), 64'(0));
            check_writes($sformatf("v%0d", v), vt[v].exp_wr);
        end
        // len=0: done two cycles after start, no operand, no writes
        clear();
        lat = 1; stub = 1'b0;
        pulse_start(5'd0);
        wait_done(cyc);
        chk("len0_done_cycle", 64'(cyc), 64'(2));
        settle();
        chk("len0_writes", 64'(nw), 64'(0));
        chk("len0_en", 64'(en_cnt), 64'(0));
        chk("len0_done_pulses", 64'(ndone), 64'(1));
        // abort two cycles into word 1's RUN
        clear();
        lat = 3;
        pulse_start(5'd8);
        wait_word1();
        repeat (2) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_sig_en", 64'(bus.sig_en), 64'(0));
        wait_done(cyc);
        settle();
        chk("abort_writes", 64'(nw), 64'(1));
        chk("abort_en_cycles", 64'(en_cnt), 64'(7));
        chk("abort_done_pulses", 64'(ndone), 64'(1));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_err", 64'(err), 64'(0));
        check_writes("abort", 1);
        // full batch with a second start mid-run
        clear();
        lat = 2;
        pulse_start(5'd16);
        repeat (20) @(posedge clk);
        #1;
        start = 1'b1;
        len = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc);
        settle();
        chk("full_writes", 64'(nw), 64'(16));
        chk("full_en_cycles", 64'(en_cnt), 64'(48));
        chk("full_gap", 64'(gap_bad), 64'(0));
        chk("full_done_pulses", 64'(ndone), 64'(1));
        chk("full_busy", 64'(busy), 64'(0));
        check_writes("full", 16);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
